// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit positions and address field layout
// for the multi-channel timer block.
package timer_pkg;

  typedef enum logic [3:0] {
    REG_CTRL  = 4'h0,
    REG_COUNT = 4'h4,
    REG_VALUE = 4'h8,
    REG_PRESC = 4'hC
  } reg_off_e;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_INT_EN = 1;
  localparam int CTRL_PEND   = 2;
  localparam int CTRL_MODE   = 3;

  localparam int CH_LSB  = 4;
  localparam int CH_MSB  = 6;
  localparam int OFF_LSB = 0;
  localparam int OFF_MSB = 3;

  // Field order matches the CTRL bit positions above, so a cast reads back directly.
  typedef struct packed {
    logic mode;
    logic pending;
    logic int_en;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/timer_ch.sv
// One timer channel: CTRL/COUNT/VALUE/PRESC registers, prescaler,
// up-counter with expiry, and its register read mux.
module timer_ch
  import timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [3:0]  off,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  ctrl_t              ctrl;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   value;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] div;
  logic               tick;
  logic               expire;
  logic               ctrl_wr;
  logic               unused_wdata;

  assign tick    = ctrl.en && (div == presc);
  // ">=" rather than "==" so a VALUE lowered under COUNT expires instead of wrapping.
  assign expire  = tick && (count >= value);
  assign ctrl_wr = wr && (off == REG_CTRL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl  <= '0;
      count <= '0;
      value <= '0;
      presc <= '0;
      div   <= '0;
    end else begin
      if (!ctrl.en) begin
        div   <= '0;
        count <= '0;
      end else begin
        div <= tick ? '0 : div + PRESC_W'(1);
        if (tick) count <= expire ? '0 : count + CNT_W'(1);
      end
      // Hardware set of pending beats a same-cycle software clear.
      if (expire) ctrl.pending <= 1'b1;
      else if (ctrl_wr && wdata[CTRL_PEND]) ctrl.pending <= 1'b0;
      // Software write of en beats the one-shot auto-clear.
      if (ctrl_wr) begin
        ctrl.en     <= wdata[CTRL_EN];
        ctrl.int_en <= wdata[CTRL_INT_EN];
        ctrl.mode   <= wdata[CTRL_MODE];
      end else if (expire && !ctrl.mode) begin
        ctrl.en <= 1'b0;
      end
      if (wr && (off == REG_VALUE)) value <= wdata[CNT_W-1:0];
      if (wr && (off == REG_PRESC)) presc <= wdata[PRESC_W-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL:  rdata = 32'(ctrl);
      REG_COUNT: rdata = 32'(count);
      REG_VALUE: rdata = 32'(value);
      REG_PRESC: rdata = 32'(presc);
      default:   rdata = '0;
    endcase
  end

  assign irq          = ctrl.pending & ctrl.int_en;
  assign unused_wdata = ^wdata;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer top: address decode, per-channel write strobes,
// read-data mux and interrupt aggregation over NUM_CH timer_ch instances.
module timer_multi
  import timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       data_i,
  input  logic [31:0]       addr_i,
  input  logic              we_i,
  output logic [31:0]       data_o,
  output logic [NUM_CH-1:0] int_vec_o,
  output logic              int_sig_o
);

  logic [2:0]  ch_sel;
  logic [3:0]  off;
  logic [31:0] rd_bus [NUM_CH];
  logic        unused_addr;

  assign ch_sel      = addr_i[CH_MSB:CH_LSB];
  assign off         = addr_i[OFF_MSB:OFF_LSB];
  assign unused_addr = ^addr_i[31:CH_MSB+1];

  // Channel indices at or above NUM_CH match no instance: writes drop, reads return 0.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_ch #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .wr    (we_i && (ch_sel == 3'(g))),
      .off   (off),
      .wdata (data_i),
      .rdata (rd_bus[g]),
      .irq   (int_vec_o[g])
    );
  end

  always_comb begin
    data_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) data_o = rd_bus[i];
    end
  end

  assign int_sig_o = |int_vec_o;

endmodule
